// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing a single-ported line cache between instruction
// fetch (port 0) and data access (port 1), with hit/miss performance counters.
module cache_port_arbiter #(
  parameter int CNT_W      = 32,
  parameter int FIRST_PORT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_rd_req,
  input  logic             p0_wr_req,
  input  logic [31:0]      p0_addr,
  input  logic [31:0]      p0_wr_data,
  output logic             p0_ack,
  output logic             p0_rd_valid,
  output logic [31:0]      p0_rd_data,
  input  logic             p1_rd_req,
  input  logic             p1_wr_req,
  input  logic [31:0]      p1_addr,
  input  logic [31:0]      p1_wr_data,
  output logic             p1_ack,
  output logic             p1_rd_valid,
  output logic [31:0]      p1_rd_data,
  output logic [31:0]      c_addr,
  output logic             c_rd_req,
  output logic             c_wr_req,
  output logic [31:0]      c_wr_data,
  input  logic             c_miss,
  input  logic [31:0]      c_rd_data,
  output logic [CNT_W-1:0] acc_cnt0,
  output logic [CNT_W-1:0] acc_cnt1,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  // Seeding last-granted with the other port makes FIRST_PORT win the first tie.
  localparam logic LAST_RST = (FIRST_PORT == 1) ? 1'b0 : 1'b1;

  state_t                     state_q, state_d;
  logic                       owner_q, owner_d;
  logic                       last_q, last_d;
  logic                       rd_cmp_q, rd_cmp_d;
  logic [1:0][31:0]           hold_q, hold_d;
  logic [1:0][CNT_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]           stall_q, stall_d;

  logic        req0, req1, winner;
  logic        own_rd, own_wr;
  logic [31:0] own_addr, own_wdata;
  logic [1:0]  ack, vld;

  assign req0      = p0_rd_req | p0_wr_req;
  assign req1      = p1_rd_req | p1_wr_req;
  assign winner    = (req0 & req1) ? ~last_q : req1;
  assign own_rd    = owner_q ? p1_rd_req  : p0_rd_req;
  assign own_wr    = owner_q ? p1_wr_req  : p0_wr_req;
  assign own_addr  = owner_q ? p1_addr    : p0_addr;
  assign own_wdata = owner_q ? p1_wr_data : p0_wr_data;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rd_cmp_d  = rd_cmp_q;
    hold_d    = hold_q;
    acc_d     = acc_q;
    stall_d   = stall_q;
    ack       = 2'b00;
    vld       = 2'b00;
    c_addr    = 32'h0;
    c_rd_req  = 1'b0;
    c_wr_req  = 1'b0;
    c_wr_data = 32'h0;
    case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP && rd_cmp_q) begin
          vld[owner_q]    = 1'b1;
          hold_d[owner_q] = c_rd_data;
        end
        if (req0 | req1) begin
          owner_d = winner;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        c_addr    = own_addr;
        c_wr_data = own_wdata;
        // A combined rd+wr is served as a read; the write is dropped.
        c_rd_req  = own_rd & ~rst;
        c_wr_req  = own_wr & ~own_rd & ~rst;
        if (!(own_rd | own_wr)) begin
          state_d = IDLE;
        end else if (c_miss) begin
          stall_d = stall_q + CNT_W'(1);
        end else begin
          ack[owner_q]   = ~rst;
          acc_d[owner_q] = acc_q[owner_q] + CNT_W'(1);
          last_d         = owner_q;
          rd_cmp_d       = own_rd;
          state_d        = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= LAST_RST;
      rd_cmp_q <= 1'b0;
      hold_q   <= '0;
      acc_q    <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      rd_cmp_q <= rd_cmp_d;
      hold_q   <= hold_d;
      acc_q    <= acc_d;
      stall_q  <= stall_d;
    end
  end

  assign p0_ack      = ack[0];
  assign p1_ack      = ack[1];
  assign p0_rd_valid = vld[0];
  assign p1_rd_valid = vld[1];
  assign p0_rd_data  = vld[0] ? c_rd_data : hold_q[0];
  assign p1_rd_data  = vld[1] ? c_rd_data : hold_q[1];
  assign acc_cnt0    = acc_q[0];
  assign acc_cnt1    = acc_q[1];
  assign stall_cnt   = stall_q;

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

- Shares the single-ported line cache (addr/rd_req/wr_req/wr_data/rd_data/miss interface) between two requesters: port 0 (instruction fetch) and port 1 (data access).
- Grants the cache to one port per access using round-robin arbitration.
- Holds the grant across all miss/swap cycles and returns read data with a one-cycle valid strobe.
- Keeps access and stall counters for hit/miss performance measurement.

## Interface

Parameters:
- CNT_W, 32, width of the performance counters
- FIRST_PORT, 1, port that wins the first tied arbitration after reset

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- p0_rd_req / p1_rd_req  in  1  read request; held until the port's ack
- p0_wr_req / p1_wr_req  in  1  write request; held until the port's ack
- p0_addr / p1_addr  in  32  byte address; stable while request is held
- p0_wr_data / p1_wr_data  in  32  write word
- p0_ack / p1_ack  out  1  access accepted by the cache this cycle
- p0_rd_valid / p1_rd_valid  out  1  read data valid this cycle
- p0_rd_data / p1_rd_data  out  32  read word
- c_addr  out  32  address to cache
- c_rd_req  out  1  read request to cache
- c_wr_req  out  1  write request to cache
- c_wr_data  out  32  write word to cache
- c_miss  in  1  cache miss/busy (combinational in cache)
- c_rd_data  in  32  cache read word, registered one cycle after a read hit
- acc_cnt0 / acc_cnt1  out  CNT_W  completed accesses per port
- stall_cnt  out  CNT_W  granted cycles with c_miss=1

## Operation

- FSM states:
  - IDLE: no owner.
  - GRANT: owner's request is driven to the cache.
  - RESP: read data return cycle; arbitration for the next access happens here.
- Arbitration (in IDLE and RESP):
  - A port is requesting if rd_req|wr_req.
  - If only one port requests, that port wins.
  - If both request, the port not granted last wins.
  - After reset, "last granted" = the port that is not FIFO_PORT... specifically not FIRST_PORT, so FIRST_PORT wins the first tie.
  - On a win: owner <= winner, go to GRANT. With no request: go to IDLE.
- GRANT:
  - Cache signals carry the owner's addr, wr_data, rd_req and wr_req.
  - If owner asserts both rd_req and wr_req, only the read is presented; c_wr_req=0.
  - c_miss=1: stay in GRANT, stall_cnt+1, owner's signals continue to drive the cache.
  - c_miss=0: owner's ack=1 combinationally, owner's acc_cnt+1, last_granted <= owner, go to RESP.
- RESP:
  - If the completed access was a read: owner's rd_valid=1 and rd_data = c_rd_data. The value is also captured into the port's hold register.
  - Then arbitrate.
- pN_rd_data equals the hold register in all cycles except that port's rd_valid cycle.
- Requesters must deassert or change their request in the cycle after ack. Requests seen in RESP are treated as new accesses.
- Outside GRANT: c_rd_req=c_wr_req=0, c_addr=0, c_wr_data=0.
- Counters wrap modulo 2^CNT_W.
- A non-owner's request is ignored until it wins; its ack/rd_valid stay 0.

## Timing

- Reset values: state IDLE; all ack/rd_valid 0; rd_data 0; c_* outputs 0; all counters 0.
- Reset during a cache miss or swap:
  - c_rd_req and c_wr_req are gated by ~rst in the reset cycle.
  - The arbiter is in IDLE after the edge.
  - The cache resets on the same rst.
- Hit read, idle arbiter:
  - Cycle 0: request seen (IDLE).
  - Cycle 1: GRANT, c_rd_req=1, ack=1.
  - Cycle 2: RESP, rd_valid=1.
- Each miss cycle adds exactly one GRANT cycle; ack occurs in the first GRANT cycle with c_miss=0.
- Back-to-back accesses: RESP goes straight to GRANT, giving one access per 2 cycles on hits.
- Write hit: ack in GRANT. No rd_valid in RESP, but the RESP cycle is still spent.
- ack is a one-cycle pulse per access. rd_valid is a one-cycle pulse per read, exactly one cycle after the read's ack.

## Test plan

- Single read hit:
  - p0 reads 0x100 (warm line holding 0xDEADBEEF).
  - Required: p0_ack in cycle 1, p0_rd_valid with 0xDEADBEEF in cycle 2; acc_cnt0=1, stall_cnt=0.
- Tie after reset:
  - p0 and p1 both read hits continuously from cycle 0.
  - Required: grant order p1,p0,p1,p0 (FIRST_PORT=1), acks every 2 cycles alternating; after 8 acks acc_cnt0=acc_cnt1=4.
- Cold miss:
  - p1 reads 0x2000 with a cache miss of N cycles.
  - Required: GRANT holds with c_addr=0x2000 for N+1 cycles, stall_cnt=N, one p1_ack, one p1_rd_valid.
  - p0 requesting throughout gets no ack until RESP, then is granted.
- Write then read:
  - p1 writes 0x12345678 to 0x40, then p1 reads 0x40.
  - Required: write ack with no rd_valid; read returns 0x12345678; acc_cnt1=2.
- rd+wr simultaneously:
  - p0 asserts both.
  - Required: c_wr_req=0, c_rd_req=1, p0_rd_valid follows ack.
- Reset mid-miss:
  - Assert rst for one cycle while in GRANT with c_miss=1.
  - Required: c_rd_req=0 in the reset cycle, IDLE afterward, all counters 0, no ack or rd_valid emitted.
